qsn_pipe_param: RTL and testbench

// - Parametrised, pipelined quasi-cyclic shift network for multi-size QC-LDPC layer decoding.
// - Cyclically rotates ZMAX lanes of BW-bit messages by a per-beat shift, within a per-beat active size z.
// - Valid/ready streaming with optional pipeline stages.
// - Sits between the column-message memory and the check-node units; also used on the write-back path.

---
 rtl/qsn_pipe_param.sv | 151 +++++++++++++++
 tb/tb_qsn_pipe_param.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qsn_pipe_param.sv
// qsn_pipe_param: pipelined quasi-cyclic shift network for multi-size QC-LDPC.
// Rotates ZMAX lanes of BW-bit messages by a per-beat shift inside a per-beat
// active size z. Lanes at or above z are zeroed. Valid/ready stream, PIPE stages.
// Stage 1 registers the beat (data, z, shift, direction, legality). The rotation
// is computed from stage 1, and stages 2..PIPE carry the rotated lanes.
// SW must be at least $clog2(ZMAX+1) so that every lane index fits in a z field.
// Optional feature macro: QSN_DIR_EN adds in_dir, which selects the inverse rotation.
module qsn_pipe_param #(
    parameter int ZMAX = 85,
    parameter int BW   = 4,
    parameter int PIPE = 2,
    parameter int SW   = 7
) (
    input  logic               sys_clk,
    input  logic               rstn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SW-1:0]      in_z,
    input  logic [SW-1:0]      in_shift,
    input  logic [ZMAX*BW-1:0] in_data,
`ifdef QSN_DIR_EN
    input  logic               in_dir,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ZMAX*BW-1:0] out_data,
    output logic               err_shift,
    input  logic               err_clr
);

    localparam int W  = ZMAX * BW;
    // Wide enough for (2^SW - 1) * BW, the largest bit shift ever requested.
    localparam int AW = SW + $clog2(BW) + 1;

    logic            stall;
    logic            accept;
    logic            bad_in;
    logic            dir_in;
    logic [PIPE-1:0] vld;

    logic [W-1:0]    s1_data;
    logic [SW-1:0]   s1_z;
    logic [SW-1:0]   s1_shift;
    logic            s1_dir;
    logic            s1_bad;

    logic [W-1:0]    keep;
    logic [W-1:0]    masked;
    logic [W-1:0]    rot;
    logic [SW-1:0]   amt_r;
    logic [SW-1:0]   amt_l;

    // The whole pipeline freezes only when the output beat is refused.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;
    assign bad_in   = (in_z == '0) || (in_z > SW'(ZMAX)) || (in_shift >= in_z);

`ifdef QSN_DIR_EN
    assign dir_in = in_dir;
`else
    assign dir_in = 1'b0;
`endif

    // Valid bits form one shift register. Bubbles travel as zeros, and a stall freezes every stage.
    always_ff @(posedge sys_clk or negedge rstn) begin
        // NOTE: state registers use non-blocking assignments, so every stage samples pre-edge values.
        if (!rstn) begin
            vld <= '0;
        end else if (!stall) begin
            vld[0] <= in_valid;
            for (int k = 1; k < PIPE; k++) vld[k] <= vld[k-1];
        end
    end

    // Input register. z, shift and direction travel with the lanes, so back-to-back beats stay independent.
    always_ff @(posedge sys_clk or negedge rstn) begin
        // NOTE: data registers are reset too, so out_data reads 0 after reset and in-flight beats are discarded.
        if (!rstn) begin
            s1_data  <= '0;
            s1_z     <= '0;
            s1_shift <= '0;
            s1_dir   <= 1'b0;
            s1_bad   <= 1'b0;
        end else if (!stall) begin
            s1_data  <= in_data;
            s1_z     <= in_z;
            s1_shift <= in_shift;
            s1_dir   <= dir_in;
            s1_bad   <= bad_in;
        end
    end

    // Rotation within z: (x >> r) | (x << l), masked to lanes below z. Each shift is a log2 barrel.
    // Forward uses r=s and l=z-s. Inverse uses r=z-s and l=s. An illegal beat passes through with r=0 and l=z.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no latch is inferred.
        keep  = '0;
        amt_r = '0;
        amt_l = s1_z;
        for (int i = 0; i < ZMAX; i++) begin
            if (SW'(i) < s1_z) keep[i*BW +: BW] = '1;
        end
        if (!s1_bad) begin
            if (s1_dir) begin
                amt_r = s1_z - s1_shift;
                amt_l = s1_shift;
            end else begin
                amt_r = s1_shift;
                amt_l = s1_z - s1_shift;
            end
        end
        masked = s1_data & keep;
        rot    = ((masked >> (AW'(amt_r) * AW'(BW))) |
                  (masked << (AW'(amt_l) * AW'(BW)))) & keep;
    end

    generate
        if (PIPE == 1) begin : g_single
            assign out_data = rot;
        end else begin : g_multi
            logic [W-1:0] dq [PIPE-1];

            // Rotated lanes move through the remaining register stages and are frozen on a stall.
            always_ff @(posedge sys_clk or negedge rstn) begin
                if (!rstn) begin
                    for (int k = 0; k < PIPE - 1; k++) dq[k] <= '0;
                end else if (!stall) begin
                    dq[0] <= rot;
                    for (int k = 1; k < PIPE - 1; k++) dq[k] <= dq[k-1];
                end
            end

            assign out_data = dq[PIPE-2];
        end
    endgenerate

    assign out_valid = vld[PIPE-1];

    // Sticky error flag. Setting it takes priority over a clear in the same cycle.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            err_shift <= 1'b0;
        end else if (accept && bad_in) begin
            err_shift <= 1'b1;
        end else if (err_clr) begin
            err_shift <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qsn_pipe_param.sv
// tb_qsn_pipe_param: scoreboard bench for qsn_pipe_param (ZMAX=85, BW=4, PIPE=2).
// The driver pushes model results into a queue when each beat is accepted.
// The monitor pops and compares every beat that leaves the DUT.
// It also checks latency, stall behaviour and data hold while the output is stalled.
module tb_qsn_pipe_param;

    localparam int ZMAX = 85;
    localparam int BW   = 4;
    localparam int PIPE = 2;
    localparam int SW   = 7;
    localparam int W    = ZMAX * BW;

    logic          sys_clk  = 1'b0;
    logic          rstn     = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_dir   = 1'b0;
    logic          err_clr  = 1'b0;
    logic [SW-1:0] in_z     = '0;
    logic [SW-1:0] in_shift = '0;
    logic [W-1:0]  in_data  = '0;
    logic          in_ready;
    logic          out_valid;
    logic          err_shift;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic          hold_low = 1'b0;
    logic          rnd_ok   = 1'b1;
    logic          bp_mode  = 1'b0;

    assign out_ready = !hold_low && rnd_ok;

    int total     = 0;
    int bad       = 0;
    int cyc       = 0;
    int stall_cnt = 0;
    int n_out     = 0;

    typedef struct {
        logic [W-1:0] data;
        int           acc_cyc;
        int           stall_at;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] last_out   = '0;
    logic [W-1:0] held       = '0;
    bit           prev_stall = 1'b0;

    qsn_pipe_param #(.ZMAX(ZMAX), .BW(BW), .PIPE(PIPE), .SW(SW)) dut (
        .sys_clk   (sys_clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_z      (in_z),
        .in_shift  (in_shift),
        .in_data   (in_data),
`ifdef QSN_DIR_EN
        .in_dir    (in_dir),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_shift (err_shift),
        .err_clr   (err_clr)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc++;

    // Random back-pressure source, active only in bp_mode.
    always @(posedge sys_clk) begin
        #1;
        rnd_ok = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model written from the rotation rule using modular lane arithmetic.
    function automatic logic [W-1:0] model(input int z, input int s, input logic [W-1:0] d, input logic dir);
        logic [W-1:0] r;
        bit           illegal;
        int           src;
        r = '0;
        illegal = (z == 0) || (z > ZMAX) || (s >= z);
        for (int j = 0; j < ZMAX; j++) begin
            if (j < z) begin
                if (illegal)  src = j;
                else if (dir) src = (j - s + z) % z;
                else          src = (j + s) % z;
                r[j*BW +: BW] = d[src*BW +: BW];
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] ramp();
        logic [W-1:0] d;
        d = '0;
        for (int j = 0; j < ZMAX; j++) d[j*BW +: BW] = BW'(j % 16);
        return d;
    endfunction

    function automatic logic [W-1:0] rnd_data();
        logic [W-1:0] d;
        d = '0;
        for (int j = 0; j < ZMAX; j++) d[j*BW +: BW] = BW'($urandom);
        return d;
    endfunction

    // Presents one beat, waits for acceptance and records the expected result.
    task automatic send(input int z, input int s, input logic [W-1:0] d, input logic dir);
        int   guard;
        exp_t e;
        guard    = 0;
        in_valid = 1'b1;
        in_z     = SW'(z);
        in_shift = SW'(s);
        in_data  = d;
        in_dir   = dir;
        forever begin
            @(negedge sys_clk);
            if (in_ready) break;
            guard++;
            if (guard > 200) break;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: beat z=%0d s=%0d not accepted", z, s);
        end else begin
            e.data     = model(z, s, d, dir);
            e.acc_cyc  = cyc;
            e.stall_at = stall_cnt;
            sb.push_back(e);
        end
        @(posedge sys_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 500) begin
            @(negedge sys_clk);
            g++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d beats still pending", sb.size());
        end
        @(posedge sys_clk);
        #1;
    endtask

    // Monitor: compares output beats, latency, stall response and data hold.
    always @(negedge sys_clk) begin
        exp_t e;
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check1("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, held);
            end
            if (out_valid && !out_ready) begin
                check1("ready_in_stall", in_ready, 1'b0);
                stall_cnt++;
                held       = out_data;
                prev_stall = 1'b1;
            end else begin
                check1("ready_free", in_ready, 1'b1);
                prev_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %h with empty scoreboard", out_data);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", out_data, e.data);
                    check_int("latency", cyc - e.acc_cyc, PIPE + (stall_cnt - e.stall_at));
                end
                last_out = out_data;
                n_out++;
            end
        end
    end

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] tmp;
        int           n0;

        // Reset state
        rstn = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check1("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, '0);
        check1("reset_err", err_shift, 1'b0);
        rstn = 1'b1;
        #1;
        check1("reset_in_ready", in_ready, 1'b1);
        @(posedge sys_clk);
        #1;

        // Identity and single-step rotate
        d = ramp();
        send(85, 0, d, 1'b0);
        drain();
        check("identity", last_out, d);
        send(85, 1, d, 1'b0);
        drain();
        tmp = last_out;
        check_int("rot1_lane0", int'(tmp[0 +: BW]), 1);
        check_int("rot1_lane84", int'(tmp[84*BW +: BW]), 0);
        send(85, 84, d, 1'b0);
        drain();
        tmp = last_out;
        check_int("wrap_lane0", int'(tmp[0 +: BW]), 4);
        check_int("wrap_lane84", int'(tmp[84*BW +: BW]), 3);

        // Reduced size
        send(60, 59, d, 1'b0);
        drain();
        tmp = last_out;
        check_int("z60_lane0", int'(tmp[0 +: BW]), 11);
        check_int("z60_lane1", int'(tmp[1*BW +: BW]), 0);
        check("z60_upper_zero", tmp >> (60 * BW), '0);

        // Back-to-back beats with different sizes
        send(30, 5, rnd_data(), 1'b0);
        send(85, 10, rnd_data(), 1'b0);
        send(7, 6, rnd_data(), 1'b0);
        send(1, 0, rnd_data(), 1'b0);
        drain();

        // Back-pressure: 8 streamed beats with out_ready low for 3 cycles
        n0 = n_out;
        fork
            begin
                for (int n = 0; n < 8; n++) begin
                    int z;
                    z = $urandom_range(1, ZMAX);
                    send(z, $urandom_range(0, z - 1), rnd_data(), 1'b0);
                end
            end
            begin
                repeat (3) @(posedge sys_clk);
                #1;
                hold_low = 1'b1;
                repeat (3) @(posedge sys_clk);
                #1;
                hold_low = 1'b0;
            end
        join
        drain();
        check_int("bp_count", n_out - n0, 8);

        // Errors: illegal shift, set-over-clear, clear alone
        send(40, 40, d, 1'b0);
        check1("err_set", err_shift, 1'b1);
        drain();
        tmp = last_out;
        check_int("err_lane39", int'(tmp[39*BW +: BW]), 7);
        check("err_upper_zero", tmp >> (40 * BW), '0);
        err_clr = 1'b1;
        send(0, 0, rnd_data(), 1'b0);
        err_clr = 1'b0;
        check1("err_set_wins", err_shift, 1'b1);
        err_clr = 1'b1;
        @(posedge sys_clk);
        #1;
        err_clr = 1'b0;
        check1("err_cleared", err_shift, 1'b0);
        send(100, 3, rnd_data(), 1'b0);
        check1("err_big_z", err_shift, 1'b1);
        drain();
        err_clr = 1'b1;
        @(posedge sys_clk);
        #1;
        err_clr = 1'b0;

`ifdef QSN_DIR_EN
        // Forward then inverse rotation restores the data
        d = rnd_data();
        send(85, 7, d, 1'b0);
        drain();
        tmp = last_out;
        send(85, 7, tmp, 1'b1);
        drain();
        check("dir_restore", last_out, d);
`endif

        // Randomized stream with random back-pressure and occasional illegal beats
        bp_mode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            int   z;
            int   s;
            logic dir;
            z   = $urandom_range(1, ZMAX);
            s   = $urandom_range(0, z - 1);
            dir = 1'b0;
`ifdef QSN_DIR_EN
            dir = 1'($urandom_range(0, 1));
`endif
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 2))
                    0:       z = 0;
                    1:       z = $urandom_range(ZMAX + 1, 127);
                    default: s = $urandom_range(z, 127);
                endcase
            end
            send(z, s, rnd_data(), dir);
        end
        drain();
        bp_mode = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;

        // Reset asserted mid-stream discards the beats in flight
        n0 = n_out;
        send(50, 3, rnd_data(), 1'b0);
        send(20, 19, rnd_data(), 1'b0);
        rstn = 1'b0;
        #1;
        sb.delete();
        check1("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, '0);
        repeat (2) @(posedge sys_clk);
        #1;
        rstn = 1'b1;
        repeat (5) @(posedge sys_clk);
        #1;
        check_int("midrst_no_output", n_out - n0, 0);
        check1("midrst_in_ready", in_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
